// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM master controller.
package avalon_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_BURST = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   localparam logic [1:0]  ST_OK      = 2'b00;
   localparam logic [1:0]  ST_ERR     = 2'b11;
   localparam logic [1:0]  ST_TIMEOUT = 2'b10;
   localparam logic [1:0]  RESP_ERR   = 2'b11;
   localparam logic [10:0] MAXADDR    = 11'h62C;

   typedef enum logic [3:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_LOAD,
      WR_REQ,
      BST_LOAD,
      BST_DATA,
      BST_STALL,
      DONE,
      ERR,
      TOUT
   } state_e;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to zero after rollover_val; the flag is high
// while the count equals rollover_val.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count_out <= '0;
      else if (clear)
         count_out <= '0;
      else if (count_enable)
         count_out <= (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
   end

   assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/avalon_master_controller.sv
// Avalon-MM initiator: single read, single write and write burst commands.
// Optional per-phase wait limit enabled with `define AVM_TIMEOUT_EN.
module avalon_master_controller
   import avalon_pkg::*;
#(
   parameter int unsigned ADDR_W         = 13,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned BCNT_W         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [BCNT_W-1:0] cmd_burstcount,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic [1:0]        status,
   output logic              write,
   output logic              read,
   output logic              beginbursttransfer,
   output logic [BCNT_W-1:0] burstcount,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writedata,
   input  logic              end_wait,
   input  logic              readdatavalid,
   input  logic              writeresponsevalid,
   input  logic [1:0]        response,
   input  logic [DATA_W-1:0] readdata
);

   state_e            state, state_next;
   logic [ADDR_W-1:0] addr_r;
   logic [BCNT_W-1:0] bcnt_r;
   logic [BCNT_W-1:0] beat_cnt;
   logic              bst_started;
   logic              wr_acked;
   logic              accept;
   logic              slave_err;
   logic              last_beat;
   logic              wr_ack_now;
   logic              rd_capture;
   logic              tmo_hit;
   logic              unused_beat_wrap;

   assign accept     = cmd_valid && (state == IDLE);
   assign slave_err  = (response == RESP_ERR);
   assign last_beat  = (beat_cnt == bcnt_r - BCNT_W'(1));
   assign wr_ack_now = (state == WR_REQ) && end_wait && !wr_acked;
   assign rd_capture = ((state == RD_REQ) && end_wait && !slave_err && readdatavalid) ||
                       ((state == RD_DATA) && readdatavalid);

   flex_counter #(.NUM_CNT_BITS(BCNT_W)) u_beat_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (accept),
      .count_enable  ((state == BST_DATA) && end_wait),
      .rollover_val  (bcnt_r),
      .count_out     (beat_cnt),
      .rollover_flag (unused_beat_wrap)
   );

`ifdef AVM_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic             in_wait;
   logic             tmo_flag;
   logic [TMO_W-1:0] unused_tmo_cnt;

   assign in_wait = state inside {RD_REQ, RD_DATA, WR_REQ, BST_DATA, BST_STALL};

   // Cleared in the cycle before a state change so each phase starts at zero.
   flex_counter #(.NUM_CNT_BITS(TMO_W)) u_tmo_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         ((state_next != state) || !in_wait),
      .count_enable  (in_wait),
      .rollover_val  (TMO_W'(TIMEOUT_CYCLES - 1)),
      .count_out     (unused_tmo_cnt),
      .rollover_flag (tmo_flag)
   );

   assign tmo_hit = tmo_flag && in_wait;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         addr_r      <= '0;
         bcnt_r      <= '0;
         bst_started <= 1'b0;
         wr_acked    <= 1'b0;
         writedata   <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         state       <= state_next;
         rdata_valid <= 1'b0;
         if (accept) begin
            addr_r      <= cmd_address;
            bcnt_r      <= cmd_burstcount;
            bst_started <= 1'b0;
            wr_acked    <= 1'b0;
         end
         if (state == BST_DATA)
            bst_started <= 1'b1;
         if (wr_ack_now)
            wr_acked <= 1'b1;
         if (wdata_ready && wdata_valid)
            writedata <= wdata;
         if (rd_capture) begin
            rdata       <= readdata;
            rdata_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (accept) begin
               if ((cmd_op == OP_RSVD) || ((cmd_op == OP_BURST) && (cmd_burstcount == '0)))
                  state_next = ERR;
               else if (cmd_op == OP_READ)
                  state_next = RD_REQ;
               else if (cmd_op == OP_WRITE)
                  state_next = WR_LOAD;
               else
                  state_next = BST_LOAD;
            end
         RD_REQ:
            if (end_wait)
               state_next = slave_err ? ERR : (readdatavalid ? DONE : RD_DATA);
            else if (tmo_hit)
               state_next = TOUT;
         RD_DATA:
            if (readdatavalid)
               state_next = DONE;
            else if (tmo_hit)
               state_next = TOUT;
         WR_LOAD:
            if (wdata_valid)
               state_next = WR_REQ;
         // The write response may arrive with the accept or any cycle after it.
         WR_REQ:
            if (wr_ack_now && slave_err)
               state_next = ERR;
            else if ((wr_ack_now || wr_acked) && writeresponsevalid)
               state_next = DONE;
            else if (tmo_hit)
               state_next = TOUT;
         BST_LOAD:
            if (wdata_valid)
               state_next = BST_DATA;
         BST_DATA:
            if (end_wait) begin
               if (slave_err)
                  state_next = ERR;
               else if (last_beat)
                  state_next = DONE;
               else if (!wdata_valid)
                  state_next = BST_STALL;
            end else if (tmo_hit) begin
               state_next = TOUT;
            end
         BST_STALL:
            if (wdata_valid)
               state_next = BST_DATA;
            else if (tmo_hit)
               state_next = TOUT;
         DONE, ERR, TOUT:
            state_next = IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready          = (state == IDLE);
      read               = (state == RD_REQ);
      write              = ((state == WR_REQ) && !wr_acked) || (state == BST_DATA);
      beginbursttransfer = (state == BST_DATA) && !bst_started;
      wdata_ready        = (state == WR_LOAD) || (state == BST_LOAD) || (state == BST_STALL) ||
                           ((state == BST_DATA) && end_wait && !slave_err && !last_beat);
      done               = (state == DONE) || (state == ERR) || (state == TOUT);
      status             = ST_OK;
      burstcount         = '0;
      address            = '0;
      case (state)
         RD_REQ, RD_DATA, WR_REQ: begin
            burstcount = BCNT_W'(1);
            address    = addr_r;
         end
         BST_DATA, BST_STALL: begin
            burstcount = bcnt_r;
            address    = addr_r + ADDR_W'(beat_cnt);
         end
         ERR:     status = ST_ERR;
         TOUT:    status = ST_TIMEOUT;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avalon_master_controller.sv
// Scoreboard bench for avalon_master_controller; the timeout scenario runs
// when AVM_TIMEOUT_EN is defined, otherwise the unbounded-wait scenario.
module tb_avalon_master_controller;
   import avalon_pkg::*;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BCNT_W = 10;
   localparam int unsigned TMO    = 8;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_address;
   logic [BCNT_W-1:0] cmd_burstcount;
   logic [DATA_W-1:0] wdata;
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              done;
   logic [1:0]        status;
   logic              write;
   logic              read;
   logic              beginbursttransfer;
   logic [BCNT_W-1:0] burstcount;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic              end_wait;
   logic              readdatavalid;
   logic              writeresponsevalid;
   logic [1:0]        response;
   logic [DATA_W-1:0] readdata;

   typedef struct {
      logic [1:0]        status;
      logic              chk_rdata;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   rv_cnt = 0, bb_cnt = 0, rw_cnt = 0, rd_cnt = 0, both_cnt = 0;

   avalon_master_controller #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BCNT_W(BCNT_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .status(status),
      .write(write), .read(read), .beginbursttransfer(beginbursttransfer),
      .burstcount(burstcount), .address(address), .writedata(writedata),
      .end_wait(end_wait), .readdatavalid(readdatavalid),
      .writeresponsevalid(writeresponsevalid), .response(response), .readdata(readdata)
   );

   always #5 clk = ~clk;

   always begin
      @(negedge clk);
      #2;
      if (rdata_valid)        rv_cnt++;
      if (beginbursttransfer) bb_cnt++;
      if (read || write)      rw_cnt++;
      if (read)               rd_cnt++;
      if (read && write)      both_cnt++;
   end

   task automatic next_cyc();
      @(negedge clk);
      cmd_valid          = 1'b0;
      wdata_valid        = 1'b0;
      end_wait           = 1'b0;
      readdatavalid      = 1'b0;
      writeresponsevalid = 1'b0;
      response           = 2'b00;
   endtask

   task automatic push_exp(input logic [1:0] st, input logic chk, input logic [DATA_W-1:0] d);
      exp_t e;
      e.status    = st;
      e.chk_rdata = chk;
      e.rdata     = d;
      sb.push_back(e);
   endtask

   task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [BCNT_W-1:0] bc);
      next_cyc();
      cmd_valid      = 1'b1;
      cmd_op         = op;
      cmd_address    = a;
      cmd_burstcount = bc;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL cmd_ready_at_accept: got %b want 1", cmd_ready);
      end
   endtask

   task automatic wait_done(input string name, input int max_cyc, output int waited);
      exp_t e;
      bit   seen;
      seen   = 1'b0;
      waited = 0;
      for (int i = 0; i < max_cyc; i++) begin
         next_cyc();
         #1;
         waited++;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s_done: no done within %0d cycles, want done=1", name, max_cyc);
         if (sb.size() != 0) void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      total++;
      if (status !== e.status) begin
         bad++;
         $display("FAIL %s_status: got %b want %b", name, status, e.status);
      end
      if (e.chk_rdata) begin
         total++;
         if (rdata_valid !== 1'b1 || rdata !== e.rdata) begin
            bad++;
            $display("FAIL %s_rdata: got valid=%b data=%h want valid=1 data=%h",
                     name, rdata_valid, rdata, e.rdata);
         end
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_address = '0; cmd_burstcount = '0;
      wdata = '0; wdata_valid = 1'b0; end_wait = 1'b0; readdatavalid = 1'b0;
      writeresponsevalid = 1'b0; response = '0; readdata = '0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({cmd_ready, wdata_ready, rdata_valid, done, status, write, read, beginbursttransfer} !== 9'b1_0000_0000 ||
          burstcount !== '0 || address !== '0 || writedata !== '0 || rdata !== '0) begin
         bad++;
         $display("FAIL reset_values: got ready=%b rw=%b%b done=%b addr=%h wd=%h rd=%h want ready=1 rest 0",
                  cmd_ready, read, write, done, address, writedata, rdata);
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_read();
      int w, rv0;
      rv0 = rv_cnt;
      push_exp(ST_OK, 1'b1, 32'hDEADBEEF);
      issue_cmd(OP_READ, 13'h010, '0);
      next_cyc(); #1;
      total++;
      if (read !== 1'b1 || write !== 1'b0 || address !== 13'h010) begin
         bad++;
         $display("FAIL read_req: got read=%b write=%b addr=%h want 1 0 010", read, write, address);
      end
      next_cyc(); end_wait = 1'b1;
      next_cyc(); readdatavalid = 1'b1; readdata = 32'hDEADBEEF; #1;
      total++;
      if (read !== 1'b0) begin
         bad++;
         $display("FAIL read_data_phase: got read=%b want 0", read);
      end
      wait_done("read", 10, w);
      next_cyc(); readdata = '0; #2;
      total++;
      if (rv_cnt - rv0 !== 1) begin
         bad++;
         $display("FAIL read_rv_pulses: got %0d want 1", rv_cnt - rv0);
      end
   endtask

   task automatic test_write();
      int w;
      push_exp(ST_OK, 1'b0, '0);
      issue_cmd(OP_WRITE, ADDR_W'(MAXADDR), '0);
      next_cyc(); wdata = 32'h12345678; wdata_valid = 1'b1; #1;
      total++;
      if (wdata_ready !== 1'b1 || write !== 1'b0) begin
         bad++;
         $display("FAIL write_load: got wdata_ready=%b write=%b want 1 0", wdata_ready, write);
      end
      for (int i = 0; i < 3; i++) begin
         next_cyc(); wdata = 32'hFFFF0000;
         if (i == 2) begin end_wait = 1'b1; writeresponsevalid = 1'b1; end
         #1;
         total++;
         if (write !== 1'b1 || address !== 13'h62C || writedata !== 32'h12345678) begin
            bad++;
            $display("FAIL write_hold_%0d: got write=%b addr=%h wd=%h want 1 62c 12345678",
                     i, write, address, writedata);
         end
      end
      wait_done("write", 10, w);
   endtask

   task automatic test_burst();
      int w, bb0;
      logic [ADDR_W-1:0] exp_addr [4];
      logic [DATA_W-1:0] exp_wd [4];
      int k;
      bb0 = bb_cnt;
      for (int i = 0; i < 4; i++) begin
         exp_addr[i] = ADDR_W'(13'h100 + i);
         exp_wd[i]   = DATA_W'(i + 1);
      end
      push_exp(ST_OK, 1'b0, '0);
      issue_cmd(OP_BURST, 13'h100, 10'd4);
      next_cyc(); wdata = 32'd1; wdata_valid = 1'b1;
      k = 0;
      // beats 1..4 with a two-cycle data gap ahead of beat 3
      for (int c = 0; c < 6; c++) begin
         next_cyc();
         if (c == 2 || c == 3) begin
            if (c == 3) begin wdata = 32'd3; wdata_valid = 1'b1; end
            #1;
            total++;
            if (write !== 1'b0) begin
               bad++;
               $display("FAIL burst_stall_%0d: got write=%b want 0", c, write);
            end
         end else begin
            end_wait = 1'b1;
            if (k < 3 && c != 1) begin wdata = DATA_W'(k + 2); wdata_valid = 1'b1; end
            #1;
            total++;
            if (write !== 1'b1 || address !== exp_addr[k] || writedata !== exp_wd[k] ||
                burstcount !== 10'd4 || beginbursttransfer !== (k == 0)) begin
               bad++;
               $display("FAIL burst_beat_%0d: got w=%b a=%h d=%h bc=%0d bbt=%b want 1 %h %h 4 %b",
                        k, write, address, writedata, burstcount, beginbursttransfer,
                        exp_addr[k], exp_wd[k], k == 0);
            end
            total++;
            if (wdata_ready !== (k < 3)) begin
               bad++;
               $display("FAIL burst_wready_%0d: got %b want %b", k, wdata_ready, k < 3);
            end
            k++;
         end
      end
      wait_done("burst", 10, w);
      total++;
      if (w !== 1 || bb_cnt - bb0 !== 1) begin
         bad++;
         $display("FAIL burst_done_timing: got wait=%0d bbt_cycles=%0d want 1 1", w, bb_cnt - bb0);
      end
   endtask

   task automatic test_read_error();
      int w, rv0;
      rv0 = rv_cnt;
      push_exp(ST_ERR, 1'b0, '0);
      issue_cmd(OP_READ, 13'h020, '0);
      next_cyc(); end_wait = 1'b1; response = RESP_ERR; readdatavalid = 1'b1; readdata = 32'hBAD0BAD0;
      wait_done("read_err", 10, w);
      next_cyc(); #2;
      total++;
      if (cmd_ready !== 1'b1 || rv_cnt - rv0 !== 0) begin
         bad++;
         $display("FAIL read_err_after: got ready=%b rv=%0d want 1 0", cmd_ready, rv_cnt - rv0);
      end
   endtask

   task automatic test_rejected();
      int w, rw0;
      rw0 = rw_cnt;
      push_exp(ST_ERR, 1'b0, '0);
      issue_cmd(OP_RSVD, 13'h030, 10'd2);
      wait_done("reject_rsvd", 5, w);
      total++;
      if (w !== 1) begin
         bad++;
         $display("FAIL reject_rsvd_latency: got %0d want 1", w);
      end
      push_exp(ST_ERR, 1'b0, '0);
      issue_cmd(OP_BURST, 13'h040, 10'd0);
      wait_done("reject_bc0", 5, w);
      total++;
      if (w !== 1 || rw_cnt - rw0 !== 0) begin
         bad++;
         $display("FAIL reject_bc0: got latency=%0d bus_cycles=%0d want 1 0", w, rw_cnt - rw0);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      push_exp(ST_OK, 1'b1, 32'hA5A50F0F);
      issue_cmd(OP_READ, 13'h1FFF, '0);
      next_cyc(); end_wait = 1'b1; readdatavalid = 1'b1; readdata = 32'hA5A50F0F;
      wait_done("fast_read", 5, w);
      total++;
      if (w !== 1) begin
         bad++;
         $display("FAIL fast_read_latency: got %0d want 1", w);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit saw_done;
      issue_cmd(OP_BURST, 13'h050, 10'd3);
      next_cyc(); wdata = 32'h55; wdata_valid = 1'b1;
      next_cyc(); #1;
      n_rst = 1'b0;
      #1;
      total++;
      if ({cmd_ready, wdata_ready, rdata_valid, done, status, write, read, beginbursttransfer} !== 9'b1_0000_0000 ||
          burstcount !== '0 || address !== '0 || writedata !== '0 || rdata !== '0) begin
         bad++;
         $display("FAIL reset_mid_burst: got ready=%b w=%b bbt=%b addr=%h wd=%h rd=%h want ready=1 rest 0",
                  cmd_ready, write, beginbursttransfer, address, writedata, rdata);
      end
      next_cyc();
      n_rst = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cyc(); #1;
         if (done) saw_done = 1'b1;
      end
      total++;
      if (saw_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_done: got done after reset, want none");
      end
   endtask

`ifdef AVM_TIMEOUT_EN
   task automatic test_timeout();
      int w, rd0;
      rd0 = rd_cnt;
      push_exp(ST_TIMEOUT, 1'b0, '0);
      issue_cmd(OP_READ, 13'h060, '0);
      wait_done("timeout", 30, w);
      next_cyc(); #2;
      total++;
      if (rd_cnt - rd0 !== int'(TMO)) begin
         bad++;
         $display("FAIL timeout_read_cycles: got %0d want %0d", rd_cnt - rd0, TMO);
      end
   endtask
`else
   task automatic test_no_timeout();
      int  w;
      bit  saw_done;
      saw_done = 1'b0;
      push_exp(ST_OK, 1'b1, 32'h0BADF00D);
      issue_cmd(OP_READ, 13'h060, '0);
      for (int i = 0; i < 80; i++) begin
         next_cyc(); #1;
         if (done) saw_done = 1'b1;
      end
      total++;
      if (saw_done !== 1'b0 || read !== 1'b1) begin
         bad++;
         $display("FAIL no_timeout_wait: got done_seen=%b read=%b want 0 1", saw_done, read);
      end
      next_cyc(); end_wait = 1'b1; readdatavalid = 1'b1; readdata = 32'h0BADF00D;
      wait_done("late_read", 5, w);
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_write();
      test_burst();
      test_read_error();
      test_rejected();
      test_back_to_back();
`ifdef AVM_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_burst();
      total++;
      if (both_cnt !== 0 || sb.size() !== 0) begin
         bad++;
         $display("FAIL final_state: got read&write cycles=%0d pending=%0d want 0 0", both_cnt, sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avalon_master_controller.md
Name: avalon_master_controller

Overview:
- Avalon-MM initiator that drives the accelerator's Avalon slave interface: single-word reads, single-word writes and write bursts.
- Accepts one command at a time from the host-side sequencer on a valid/ready handshake and streams burst write data from a valid/ready data port.
- Returns read data and a completion status.
- Sits between the host sequencer/testbench driver and the slave controller's bus pins.

Parameters:
- ADDR_W, 13, Avalon address width.
- DATA_W, 32, data width.
- BCNT_W, 10, burstcount width.
- TIMEOUT_CYCLES, 64, wait-cycle limit per bus phase; used only with AVM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle; command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  00 read, 01 write, 10 burst write, 11 reserved
- cmd_address  in  ADDR_W  start address
- cmd_burstcount  in  BCNT_W  beats for burst write
- wdata  in  DATA_W  write data stream
- wdata_valid  in  1  wdata valid
- wdata_ready  out  1  beat consumed when wdata_valid&&wdata_ready
- rdata  out  DATA_W  captured read data
- rdata_valid  out  1  one-cycle pulse with rdata
- done  out  1  one-cycle pulse, command finished
- status  out  2  valid with done: 00 OK, 11 slave error / rejected command, 10 timeout
- write  out  1  Avalon write
- read  out  1  Avalon read
- beginbursttransfer  out  1  first burst cycle
- burstcount  out  BCNT_W  burst length
- address  out  ADDR_W  Avalon address
- writedata  out  DATA_W  Avalon write data
- end_wait  in  1  slave accepted current transfer/beat
- readdatavalid  in  1  slave read data valid
- writeresponsevalid  in  1  slave single-write response valid
- response  in  2  slave response; 11 = error
- readdata  in  DATA_W  slave read data

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State IDLE, beat counter 0.
- Asserting n_rst mid-command aborts immediately. No done is issued.
- IDLE: cmd_ready=1. On accept, register op/address/burstcount.
  - op 11, or op 10 with burstcount 0: go to ERR, no bus activity.
  - Otherwise go to RD_REQ, WR_LOAD or BST_LOAD.
- RD_REQ: read=1, address held. On end_wait=1:
  - If response=11: go to ERR.
  - Else go to RD_DATA. If readdatavalid is also high this cycle, capture now and go straight to DONE.
- RD_DATA: read=0. On readdatavalid: rdata<=readdata, rdata_valid pulse, go to DONE.
- WR_LOAD: wdata_ready=1. On wdata_valid, latch writedata and go to WR_REQ.
- WR_REQ: write=1 until end_wait.
  - response=11 on end_wait: go to ERR.
  - writeresponsevalid is allowed in the same cycle as end_wait or later. Completion requires both; then go to DONE.
- BST_LOAD: wait for first wdata beat, latch it, go to BST_DATA.
- BST_DATA:
  - write=1 and burstcount=registered value; beginbursttransfer=1 only in the first cycle of the burst.
  - address = start + beat count, modulo 2^ADDR_W.
  - Each end_wait increments the beat count.
  - If more beats remain, wdata_ready=1 in that cycle and the next beat is latched.
  - If wdata_valid=0 at that point, write drops to 0 and the controller stalls in BST_STALL until data arrives. beginbursttransfer is not re-asserted.
  - After beat burstcount is accepted: go to DONE. No writeresponsevalid is required for bursts.
  - response=11 on any beat: go to ERR. Remaining stream beats are not consumed.
- DONE: done=1, status=00, go to IDLE.
- ERR: done=1, status=11, go to IDLE.
- read and write are never high in the same cycle.
- Latency: minimum single read = 3 cycles from accept to done with the slave's 2-cycle handshake.

Optional Feature:
- AVM_TIMEOUT_EN defined: a wait counter clears on each state entry and counts cycles spent in RD_REQ, RD_DATA, WR_REQ, BST_DATA or BST_STALL. On reaching TIMEOUT_CYCLES: deassert read/write, done=1, status=10, return to IDLE.
- Undefined: no counter; the controller waits indefinitely.

Decomposition:
- Package avalon_pkg holds:
  - op enum: OP_READ, OP_WRITE, OP_BURST, OP_RSVD;
  - status constants: ST_OK, ST_ERR, ST_TIMEOUT;
  - RESP_ERR=2'b11;
  - MAXADDR=11'h62C.
- Beat counter is an instance of flex_counter #(10), cleared on command accept, rollover = registered burstcount.
- The timeout counter is a second flex_counter instance.

Test Plan:
- Read addr 0x010, slave end_wait at cycle 2, readdatavalid cycle 3 with 0xDEADBEEF -> rdata=0xDEADBEEF, one rdata_valid pulse, done with status=00.
- Write addr 0x62C data 0x12345678, slave asserts end_wait+writeresponsevalid together -> writedata/address held until then, done with status=00.
- Burst of 4 at 0x100, wdata 1..4, wdata_valid dropped for 2 cycles before beat 3 -> beginbursttransfer only in cycle 1; addresses 0x100..0x103; write low during stall; done after 4th end_wait.
- Read with slave response=11 on end_wait -> no rdata_valid, done with status=11, cmd_ready=1 next cycle.
- cmd_op=11 and burst with burstcount=0 -> no read/write activity, done with status=11 one cycle later.
- With AVM_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts end_wait -> read held for 8 cycles, then done with status=10; reset asserted mid-burst -> all outputs at reset values immediately.
